// File: rtl/irq_bridge_ctrl.sv
// Bridge interrupt controller: latches device IRQs as pending, masks them and drives a registered HWInt vector.
// Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module irq_bridge_ctrl #(
  parameter int          N_SRC     = 3,
  parameter logic [31:0] BASE_ADDR = 32'h7F20,
  parameter logic [5:0]  MASK_RST  = 6'h3F,
  parameter logic [5:0]  EDGE_RST  = 6'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_byteen,
  output logic [31:0]      bus_rdata,
  output logic [5:0]       hwint
);

  logic [N_SRC-1:0] src_s;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  logic [N_SRC-1:0] src_q, pend_q, mask_q, edge_q, hwint_q;
  logic [N_SRC-1:0] pend_d, mask_d, edge_d, hwint_d;
  logic [N_SRC-1:0] rise, set, clr;
  logic             hit, wr;
  logic [1:0]       off;
  logic             unused_bits;

  assign hit = (bus_addr & ~32'hF) == BASE_ADDR;
  assign off = bus_addr[3:2];
  assign wr  = hit & bus_byteen[0];
  assign unused_bits = ^{bus_wdata[31:N_SRC], bus_byteen[3:1]};

  // Set wins over a same-cycle W1C so a fresh interrupt is never lost.
  always_comb begin
    rise    = src_s & ~src_q;
    set     = (edge_q & rise) | (~edge_q & src_s);
    clr     = (wr && off == 2'd0) ? bus_wdata[N_SRC-1:0] : '0;
    pend_d  = (pend_q & ~clr) | set;
    mask_d  = (wr && off == 2'd1) ? bus_wdata[N_SRC-1:0] : mask_q;
    edge_d  = (wr && off == 2'd2) ? bus_wdata[N_SRC-1:0] : edge_q;
    hwint_d = pend_d & mask_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RST[N_SRC-1:0];
      edge_q  <= EDGE_RST[N_SRC-1:0];
      hwint_q <= '0;
    end else begin
      src_q   <= src_s;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      hwint_q <= hwint_d;
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      case (off)
        2'd0:    bus_rdata[N_SRC-1:0] = pend_q;
        2'd1:    bus_rdata[N_SRC-1:0] = mask_q;
        2'd2:    bus_rdata[N_SRC-1:0] = edge_q;
        default: bus_rdata[N_SRC-1:0] = src_s;
      endcase
    end
  end

  always_comb begin
    hwint = '0;
    hwint[N_SRC-1:0] = hwint_q;
  end

endmodule
